// File: rtl/result_drain_pkg.sv
// ----------------------------------------------------------------------------
// result_drain_pkg
// Shared types and defaults for result_drain_buffer and its skew write
// generator.
//   state_t       : controller states (idle, wavefront capture, serial drain)
//   NUM_LANES_DEF : default number of array columns feeding the buffer
//   MAX_ROWS_DEF  : default maximum rows held per result tile
//   clamp_dim()   : limits a requested tile dimension to what the storage holds
// ----------------------------------------------------------------------------
package result_drain_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_DRAIN   = 2'd2
    } state_t;

    localparam int NUM_LANES_DEF = 8;
    localparam int MAX_ROWS_DEF  = 16;

    function automatic logic [31:0] clamp_dim(input logic [31:0] dim,
                                              input logic [31:0] limit);
        return (dim > limit) ? limit : dim;
    endfunction

endpackage

// File: rtl/result_drain_buffer_skew_write_gen.sv
// ----------------------------------------------------------------------------
// skew_write_gen
// Combinational write-address generator for the deskew storage. At capture
// step t, lane c carries row t-c of the result tile, so lane c writes
// mem[t-c][c] when c < N and 0 <= t-c < M.
// Ports:
//   i_t   : current capture step
//   i_m   : active tile rows M (already clamped)
//   i_n   : active tile columns N (already clamped)
//   o_we  : per-lane write enable
//   o_row : per-lane destination row (t-c), lane c at [c*RW +: RW]
// ----------------------------------------------------------------------------
module skew_write_gen #(
    parameter int NUM_LANES   = 8,
    parameter int MAX_ROWS    = 16,
    parameter int INDEX_WIDTH = 8,
    parameter int TW          = INDEX_WIDTH + 2,
    parameter int RW          = $clog2(MAX_ROWS)
) (
    input  logic [TW-1:0]           i_t,
    input  logic [INDEX_WIDTH-1:0]  i_m,
    input  logic [INDEX_WIDTH-1:0]  i_n,
    output logic [NUM_LANES-1:0]    o_we,
    output logic [NUM_LANES*RW-1:0] o_row
);

    for (genvar c = 0; c < NUM_LANES; c++) begin : g_lane
        logic [31:0] w_diff;

        // t-c wraps to a huge value when t < c, but that case is already
        // excluded by the t >= c term, so the unsigned compare stays valid.
        assign w_diff   = 32'(i_t) - 32'(c);
        assign o_we[c]  = (32'(c) < 32'(i_n)) &&
                          (32'(i_t) >= 32'(c)) &&
                          (w_diff < 32'(i_m));
        assign o_row[c*RW +: RW] = RW'(w_diff);
    end

endmodule

// File: rtl/result_drain_buffer.sv
// ----------------------------------------------------------------------------
// result_drain_buffer
// Collects the diagonally skewed partial-sum wavefront leaving the bottom of
// the systolic array, deskews it into a row-major tile and drains the tile one
// element at a time over a valid/ready stream.
// Ports:
//   i_clk        : clock, all logic on rising edge
//   i_reset_n    : synchronous active-low reset
//   i_start      : begin a tile (honoured only while idle)
//   i_num_rows   : requested tile rows, clamped to MAX_ROWS
//   i_num_cols   : requested tile columns, clamped to NUM_LANES
//   i_in_valid   : i_psum_in carries a capture step
//   i_psum_in    : lane c at [c*ACC_WIDTH +: ACC_WIDTH]
//   o_out_data   : drained element
//   o_out_valid  : o_out_data valid
//   i_out_ready  : consumer accepts the current element
//   o_out_last   : current element is the final one of the tile
//   o_busy       : capture or drain in progress
//   o_done       : one-cycle pulse when the tile completes
// Build option:
//   RESULT_DRAIN_RELU_EN : negative elements are replaced by zero on drain.
// ----------------------------------------------------------------------------
module result_drain_buffer
    import result_drain_pkg::*;
#(
    parameter int ACC_WIDTH   = 32,
    parameter int NUM_LANES   = NUM_LANES_DEF,
    parameter int MAX_ROWS    = MAX_ROWS_DEF,
    parameter int INDEX_WIDTH = 8
) (
    input  logic                           i_clk,
    input  logic                           i_reset_n,
    input  logic                           i_start,
    input  logic [INDEX_WIDTH-1:0]         i_num_rows,
    input  logic [INDEX_WIDTH-1:0]         i_num_cols,
    input  logic                           i_in_valid,
    input  logic [NUM_LANES*ACC_WIDTH-1:0] i_psum_in,
    output logic [ACC_WIDTH-1:0]           o_out_data,
    output logic                           o_out_valid,
    input  logic                           i_out_ready,
    output logic                           o_out_last,
    output logic                           o_busy,
    output logic                           o_done
);

    localparam int RW = $clog2(MAX_ROWS);
    localparam int CW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam int TW = INDEX_WIDTH + 2;

    state_t                   r_state;
    logic [INDEX_WIDTH-1:0]   r_m;
    logic [INDEX_WIDTH-1:0]   r_n;
    logic [TW-1:0]            r_t;
    logic [RW-1:0]            r_row;
    logic [CW-1:0]            r_col;
    logic [ACC_WIDTH-1:0]     r_mem [MAX_ROWS][NUM_LANES];

    logic [NUM_LANES-1:0]     w_we;
    logic [NUM_LANES*RW-1:0]  w_row;
    logic                     w_is_last_step;
    logic                     w_col_wrap;
    logic [RW-1:0]            w_next_row;
    logic [CW-1:0]            w_next_col;
    logic                     w_next_is_last;
    logic [ACC_WIDTH-1:0]     w_first_elem;

    function automatic logic [ACC_WIDTH-1:0] drain_xform(input logic [ACC_WIDTH-1:0] e);
`ifdef RESULT_DRAIN_RELU_EN
        return e[ACC_WIDTH-1] ? '0 : e;
`else
        return e;
`endif
    endfunction

    skew_write_gen #(
        .NUM_LANES   (NUM_LANES),
        .MAX_ROWS    (MAX_ROWS),
        .INDEX_WIDTH (INDEX_WIDTH),
        .TW          (TW),
        .RW          (RW)
    ) u_skew_write_gen (
        .i_t   (r_t),
        .i_m   (r_m),
        .i_n   (r_n),
        .o_we  (w_we),
        .o_row (w_row)
    );

    assign w_is_last_step = (32'(r_t) == (32'(r_m) + 32'(r_n) - 32'd2));

    assign w_col_wrap     = (32'(r_col) == (32'(r_n) - 32'd1));
    assign w_next_col     = w_col_wrap ? '0 : r_col + CW'(1);
    assign w_next_row     = w_col_wrap ? r_row + RW'(1) : r_row;
    assign w_next_is_last = (32'(w_next_row) == (32'(r_m) - 32'd1)) &&
                            (32'(w_next_col) == (32'(r_n) - 32'd1));

    // For a 1x1 tile the only step (t=0) is also the last one, so mem[0][0]
    // is being written on the very edge that loads the first drain element.
    assign w_first_elem = (r_t == '0) ? i_psum_in[ACC_WIDTH-1:0] : r_mem[0][0];

    // Tile storage: no reset, contents are always rewritten before being read.
    always_ff @(posedge i_clk) begin
        if (r_state == S_CAPTURE && i_in_valid) begin
            for (int c = 0; c < NUM_LANES; c++) begin
                if (w_we[c]) begin
                    r_mem[w_row[c*RW +: RW]][c] <= i_psum_in[c*ACC_WIDTH +: ACC_WIDTH];
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state     <= S_IDLE;
            r_m         <= '0;
            r_n         <= '0;
            r_t         <= '0;
            r_row       <= '0;
            r_col       <= '0;
            o_out_data  <= '0;
            o_out_valid <= 1'b0;
            o_out_last  <= 1'b0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
        end else begin
            o_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_m <= INDEX_WIDTH'(clamp_dim(32'(i_num_rows), 32'(MAX_ROWS)));
                        r_n <= INDEX_WIDTH'(clamp_dim(32'(i_num_cols), 32'(NUM_LANES)));
                        r_t <= '0;
                        // An empty tile completes immediately without output.
                        if (i_num_rows == '0 || i_num_cols == '0) begin
                            o_done <= 1'b1;
                        end else begin
                            r_state <= S_CAPTURE;
                            o_busy  <= 1'b1;
                        end
                    end
                end

                S_CAPTURE: begin
                    if (i_in_valid) begin
                        if (w_is_last_step) begin
                            r_state     <= S_DRAIN;
                            r_row       <= '0;
                            r_col       <= '0;
                            o_out_data  <= drain_xform(w_first_elem);
                            o_out_valid <= 1'b1;
                            o_out_last  <= (r_m == INDEX_WIDTH'(1)) && (r_n == INDEX_WIDTH'(1));
                        end else begin
                            r_t <= r_t + TW'(1);
                        end
                    end
                end

                S_DRAIN: begin
                    if (i_out_ready) begin
                        if (o_out_last) begin
                            r_state     <= S_IDLE;
                            o_out_valid <= 1'b0;
                            o_out_last  <= 1'b0;
                            o_busy      <= 1'b0;
                            o_done      <= 1'b1;
                        end else begin
                            // Prefetch the next element so transfers run back to back.
                            r_row      <= w_next_row;
                            r_col      <= w_next_col;
                            o_out_data <= drain_xform(r_mem[w_next_row][w_next_col]);
                            o_out_last <= w_next_is_last;
                        end
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_result_drain_buffer.sv
// ----------------------------------------------------------------------------
// tb_result_drain_buffer
// Randomized bench for result_drain_buffer. Each tile is described as a
// row-major list of expected elements; the skewed lane stimulus is derived
// from that list (lane c at step t carries element (t-c, c)), and the drained
// stream is compared against the list in order.
// ----------------------------------------------------------------------------
module tb_result_drain_buffer;

    localparam int ACC_WIDTH   = 32;
    localparam int NUM_LANES   = 8;
    localparam int MAX_ROWS    = 16;
    localparam int INDEX_WIDTH = 8;

    logic                           i_clk = 1'b0;
    logic                           i_reset_n;
    logic                           i_start;
    logic [INDEX_WIDTH-1:0]         i_num_rows;
    logic [INDEX_WIDTH-1:0]         i_num_cols;
    logic                           i_in_valid;
    logic [NUM_LANES*ACC_WIDTH-1:0] i_psum_in;
    logic [ACC_WIDTH-1:0]           o_out_data;
    logic                           o_out_valid;
    logic                           i_out_ready;
    logic                           o_out_last;
    logic                           o_busy;
    logic                           o_done;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 i_clk = ~i_clk;

    result_drain_buffer #(
        .ACC_WIDTH   (ACC_WIDTH),
        .NUM_LANES   (NUM_LANES),
        .MAX_ROWS    (MAX_ROWS),
        .INDEX_WIDTH (INDEX_WIDTH)
    ) dut (
        .i_clk       (i_clk),
        .i_reset_n   (i_reset_n),
        .i_start     (i_start),
        .i_num_rows  (i_num_rows),
        .i_num_cols  (i_num_cols),
        .i_in_valid  (i_in_valid),
        .i_psum_in   (i_psum_in),
        .o_out_data  (o_out_data),
        .o_out_valid (o_out_valid),
        .i_out_ready (i_out_ready),
        .o_out_last  (o_out_last),
        .o_busy      (o_busy),
        .o_done      (o_done)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: observed %0h required %0h", tag, act, expv);
        end
    endtask

    function automatic logic [31:0] ref_xform(input logic [31:0] e);
`ifdef RESULT_DRAIN_RELU_EN
        return ($signed(e) < 0) ? 32'd0 : e;
`else
        return e;
`endif
    endfunction

    function automatic logic [NUM_LANES*ACC_WIDTH-1:0] rand_bus();
        logic [NUM_LANES*ACC_WIDTH-1:0] b;
        for (int i = 0; i < NUM_LANES; i++) b[i*ACC_WIDTH +: ACC_WIDTH] = $urandom;
        return b;
    endfunction

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // mode: 0 random elements (with stray starts during capture),
    //       1 lane c at step t = 16*t+c, 2 random with -5 and 7 up front
    // ready_mode: 0 always ready, 1 toggle, 2 random
    // abort_after: number of transfers before a mid-drain reset (-1 = none)
    task automatic run_tile(input int rows, input int cols, input int mode,
                            input int stall_at, input int stall_len,
                            input int ready_mode, input int abort_after);
        int m, n, total, idx, guard;
        logic [31:0] expv [$];
        logic rdy;
        logic [31:0] lane;

        m = (rows > MAX_ROWS) ? MAX_ROWS : rows;
        n = (cols > NUM_LANES) ? NUM_LANES : cols;
        total = m * n;
        expv = {};
        for (int r = 0; r < m; r++) begin
            for (int c = 0; c < n; c++) begin
                if (mode == 1)                      expv.push_back(32'(16 * (r + c) + c));
                else if (mode == 2 && r*n+c == 0)   expv.push_back(32'hFFFF_FFFB);
                else if (mode == 2 && r*n+c == 1)   expv.push_back(32'd7);
                else                                expv.push_back($urandom);
            end
        end

        i_start    = 1'b1;
        i_num_rows = 8'(rows);
        i_num_cols = 8'(cols);
        tick();
        i_start = 1'b0;

        if (total == 0) begin
            check("empty_done", o_done, 1);
            check("empty_valid", o_out_valid, 0);
            check("empty_busy", o_busy, 0);
            tick();
            check("empty_done_clr", o_done, 0);
            check("empty_valid2", o_out_valid, 0);
            return;
        end

        check("busy_capture", o_busy, 1);
        for (int t = 0; t <= m + n - 2; t++) begin
            if (t == stall_at) begin
                for (int s = 0; s < stall_len; s++) begin
                    i_in_valid = 1'b0;
                    i_psum_in  = rand_bus();
                    tick();
                end
            end
            i_in_valid = 1'b1;
            for (int c = 0; c < NUM_LANES; c++) begin
                if (mode == 1)                                lane = 32'(16 * t + c);
                else if (c < n && t - c >= 0 && t - c < m)    lane = expv[(t - c) * n + c];
                else                                          lane = $urandom;
                i_psum_in[c*ACC_WIDTH +: ACC_WIDTH] = lane;
            end
            i_start    = (mode == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
            i_num_rows = 8'($urandom_range(0, 3));
            tick();
        end
        i_in_valid = 1'b0;
        i_start    = 1'b0;
        i_psum_in  = rand_bus();

        idx   = 0;
        guard = 0;
        while (idx < total && guard < 4000) begin
            if (abort_after >= 0 && idx == abort_after) begin
                i_out_ready = 1'b0;
                i_reset_n   = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    tick();
                    check("rst_valid", o_out_valid, 0);
                    check("rst_data", o_out_data, 0);
                    check("rst_last", o_out_last, 0);
                    check("rst_busy", o_busy, 0);
                    check("rst_done", o_done, 0);
                end
                i_reset_n = 1'b1;
                tick();
                check("rst_done_after", o_done, 0);
                return;
            end
            case (ready_mode)
                0:       rdy = 1'b1;
                1:       rdy = (guard % 2 == 0);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            i_out_ready = rdy;
            check("drain_valid", o_out_valid, 1);
            check("drain_data", o_out_data, ref_xform(expv[idx]));
            check("drain_last", o_out_last, (idx == total - 1));
            check("drain_busy", o_busy, 1);
            tick();
            if (rdy) idx++;
            guard++;
        end
        if (idx < total) check("drain_timeout", idx, total);
        i_out_ready = 1'b0;

        check("end_valid", o_out_valid, 0);
        check("end_done", o_done, 1);
        check("end_busy", o_busy, 0);
        check("end_last", o_out_last, 0);
        tick();
        check("end_done_clr", o_done, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        i_reset_n   = 1'b0;
        i_start     = 1'b0;
        i_num_rows  = '0;
        i_num_cols  = '0;
        i_in_valid  = 1'b0;
        i_psum_in   = '0;
        i_out_ready = 1'b0;
        repeat (3) tick();
        check("reset_valid", o_out_valid, 0);
        check("reset_data", o_out_data, 0);
        check("reset_last", o_out_last, 0);
        check("reset_busy", o_busy, 0);
        check("reset_done", o_done, 0);
        i_reset_n = 1'b1;
        tick();

        run_tile(2, 2, 1, -1, 0, 0, -1);    // 0x00,0x11,0x10,0x21
        run_tile(16, 8, 0, -1, 0, 1, -1);   // full tile, ready toggling
        run_tile(4, 4, 0, 3, 5, 0, -1);     // stall at t=3
        run_tile(0, 5, 0, -1, 0, 0, -1);    // empty rows
        run_tile(3, 0, 0, -1, 0, 0, -1);    // empty cols
        run_tile(3, 12, 0, -1, 0, 2, -1);   // columns clamped to 8
        run_tile(20, 3, 0, 2, 2, 2, -1);    // rows clamped to 16
        run_tile(1, 2, 2, -1, 0, 0, -1);    // -5 and 7
        run_tile(1, 1, 0, -1, 0, 2, -1);    // single element
        run_tile(5, 6, 0, -1, 0, 2, 7);     // reset mid-drain
        run_tile(3, 3, 1, -1, 0, 0, -1);    // recovers after reset

        for (int k = 0; k < 6; k++) begin
            run_tile($urandom_range(1, 18), $urandom_range(1, 10), 0,
                     $urandom_range(0, 8), $urandom_range(1, 4), 2, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
